// File: rtl/demux_dispatch_ctrl_pkg.sv
// Shared decryption-datapath definitions: dispatcher FSM states, channel codes, default widths.
// Optional DEMUX_DISPATCH_ERRCNT_EN (set per build) adds the illegal-select counter elsewhere.
package decrypt_pkg;

  localparam int unsigned MST_DWIDTH_DEF = 32;
  localparam int unsigned SYS_DWIDTH_DEF = 8;
  localparam int unsigned ERRCNT_W       = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [1:0] CH_CAESAR  = 2'd0;
  localparam logic [1:0] CH_SCYTALE = 2'd1;
  localparam logic [1:0] CH_ZIGZAG  = 2'd2;
  localparam logic [1:0] CH_ILLEGAL = 2'd3;

endpackage

// File: rtl/demux_dispatch_ctrl_if.sv
// Master word handshake plus per-channel byte bus of the dispatch controller.
// DEMUX_DISPATCH_ERRCNT_EN adds err_cnt_o to the bundle and both modports.
interface demux_dispatch_ctrl_if
  import decrypt_pkg::*;
#(
  parameter int unsigned MST_DWIDTH = MST_DWIDTH_DEF,
  parameter int unsigned SYS_DWIDTH = SYS_DWIDTH_DEF
);

  logic [MST_DWIDTH-1:0] data_i;
  logic                  valid_i;
  logic [1:0]            select_i;
  logic                  ready_o;
  logic                  busy0_i;
  logic                  busy1_i;
  logic                  busy2_i;
  logic [SYS_DWIDTH-1:0] data_o;
  logic                  valid0_o;
  logic                  valid1_o;
  logic                  valid2_o;
  logic                  last_o;
  logic                  idle_o;

`ifdef DEMUX_DISPATCH_ERRCNT_EN
  logic [ERRCNT_W-1:0]   err_cnt_o;

  modport slave (
    input  data_i, valid_i, select_i, busy0_i, busy1_i, busy2_i,
    output ready_o, data_o, valid0_o, valid1_o, valid2_o, last_o, idle_o, err_cnt_o
  );

  modport master (
    output data_i, valid_i, select_i, busy0_i, busy1_i, busy2_i,
    input  ready_o, data_o, valid0_o, valid1_o, valid2_o, last_o, idle_o, err_cnt_o
  );
`else
  modport slave (
    input  data_i, valid_i, select_i, busy0_i, busy1_i, busy2_i,
    output ready_o, data_o, valid0_o, valid1_o, valid2_o, last_o, idle_o
  );

  modport master (
    output data_i, valid_i, select_i, busy0_i, busy1_i, busy2_i,
    input  ready_o, data_o, valid0_o, valid1_o, valid2_o, last_o, idle_o
  );
`endif

endinterface

// File: rtl/demux_dispatch_ctrl.sv
// Serialises one accepted word MSB-byte-first to one of three decryptor channels, honouring busy.
// DEMUX_DISPATCH_ERRCNT_EN: saturating count of words dropped for select == CH_ILLEGAL.
module demux_dispatch_ctrl
  import decrypt_pkg::*;
#(
  parameter int unsigned MST_DWIDTH = MST_DWIDTH_DEF,
  parameter int unsigned SYS_DWIDTH = SYS_DWIDTH_DEF
) (
  input  logic                  clk_sys,
  input  logic                  rst,
  demux_dispatch_ctrl_if.slave  bus
);

  localparam int unsigned BYTES      = MST_DWIDTH / SYS_DWIDTH;
  localparam int unsigned IDX_W      = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned WORD_IDX_W = (MST_DWIDTH > 1) ? $clog2(MST_DWIDTH) : 1;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [MST_DWIDTH-1:0] word_q, word_d;
  logic [1:0]            ch_q, ch_d;
  logic [SYS_DWIDTH-1:0] data_q, data_d;
  logic [2:0]            valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  ready_c;
  logic                  busy_sel_c;
  logic [WORD_IDX_W-1:0] msb_c;
`ifdef DEMUX_DISPATCH_ERRCNT_EN
  logic [ERRCNT_W-1:0]   err_q, err_d;
`endif

  // Ready is forced low while reset is asserted even though the state already reads IDLE.
  assign ready_c = (state_q == IDLE) && !rst;

  // Only the latched channel's busy can stall the transfer.
  always_comb begin
    busy_sel_c = 1'b0;
    case (ch_q)
      CH_CAESAR:  busy_sel_c = bus.busy0_i;
      CH_SCYTALE: busy_sel_c = bus.busy1_i;
      CH_ZIGZAG:  busy_sel_c = bus.busy2_i;
      default:    busy_sel_c = 1'b0;
    endcase
  end

  assign msb_c = WORD_IDX_W'(MST_DWIDTH - 1) - WORD_IDX_W'(SYS_DWIDTH * 32'(idx_q));

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    ch_d    = ch_q;
    data_d  = data_q;
    valid_d = 3'b000;
    last_d  = 1'b0;
`ifdef DEMUX_DISPATCH_ERRCNT_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.valid_i && ready_c) begin
          if (bus.select_i != CH_ILLEGAL) begin
            word_d  = bus.data_i;
            ch_d    = bus.select_i;
            idx_d   = '0;
            state_d = SEND;
          end
`ifdef DEMUX_DISPATCH_ERRCNT_EN
          else if (err_q != {ERRCNT_W{1'b1}}) begin
            err_d = err_q + ERRCNT_W'(1);
          end
`endif
        end
      end
      SEND: begin
        if (!busy_sel_c) begin
          data_d = word_q[msb_c -: SYS_DWIDTH];
          case (ch_q)
            CH_CAESAR:  valid_d = 3'b001;
            CH_SCYTALE: valid_d = 3'b010;
            CH_ZIGZAG:  valid_d = 3'b100;
            default:    valid_d = 3'b000;
          endcase
          if (idx_q == IDX_W'(BYTES - 1)) begin
            last_d  = 1'b1;
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      word_q  <= '0;
      ch_q    <= CH_CAESAR;
      data_q  <= '0;
      valid_q <= 3'b000;
      last_q  <= 1'b0;
`ifdef DEMUX_DISPATCH_ERRCNT_EN
      err_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      ch_q    <= ch_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
`ifdef DEMUX_DISPATCH_ERRCNT_EN
      err_q   <= err_d;
`endif
    end
  end

  assign bus.ready_o  = ready_c;
  assign bus.idle_o   = (state_q == IDLE) && (valid_q == 3'b000);
  assign bus.data_o   = data_q;
  assign bus.valid0_o = valid_q[0];
  assign bus.valid1_o = valid_q[1];
  assign bus.valid2_o = valid_q[2];
  assign bus.last_o   = last_q;
`ifdef DEMUX_DISPATCH_ERRCNT_EN
  assign bus.err_cnt_o = err_q;
`endif

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Directed bench for demux_dispatch_ctrl: vector table of words plus hand sequences for
// illegal select, back-to-back accept and asynchronous reset; DEMUX_DISPATCH_ERRCNT_EN aware.
module tb_demux_dispatch_ctrl;
  import decrypt_pkg::*;

  logic clk_sys = 1'b0;
  logic rst;

  always #5 clk_sys = ~clk_sys;

  demux_dispatch_ctrl_if bus ();

  demux_dispatch_ctrl dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .bus     (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [7:0]  prev_byte = 8'h00;

  typedef struct {
    logic [31:0]      data;
    logic [1:0]       sel;
    int               stall_at;
    int               stall_len;
    bit               toggle0;
    logic [0:3][7:0]  exp_b;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] vmask();
    return {bus.valid2_o, bus.valid1_o, bus.valid0_o};
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Accept one legal word and walk it byte by byte, inserting the vector's busy stall.
  task automatic send(input vec_t v);
    int nb;
    int ns;
    bit stall;
    nb = 0;
    ns = 0;
    bus.valid_i  = 1'b1;
    bus.data_i   = v.data;
    bus.select_i = v.sel;
    tick();
    bus.valid_i  = 1'b0;
    bus.data_i   = 32'hFFFF_FFFF;
    bus.select_i = 2'd3;
    chk("accept_ready", 32'(bus.ready_o), 32'd0);
    for (int cyc = 0; cyc < 4 + v.stall_len; cyc++) begin
      stall = (nb == v.stall_at) && (ns < v.stall_len);
      bus.busy0_i = (v.sel == 2'd0) ? stall : (v.toggle0 ? cyc[0] : 1'b0);
      bus.busy1_i = (v.sel == 2'd1) ? stall : 1'b0;
      bus.busy2_i = (v.sel == 2'd2) ? stall : 1'b0;
      tick();
      if (stall) begin
        ns++;
        chk("stall_valid", 32'(vmask()), 32'd0);
        chk("stall_hold", 32'(bus.data_o), 32'(prev_byte));
        chk("stall_last", 32'(bus.last_o), 32'd0);
        chk("stall_ready", 32'(bus.ready_o), 32'd0);
      end else begin
        chk("byte_valid", 32'(vmask()), 32'(3'b001 << v.sel));
        chk("byte_data", 32'(bus.data_o), 32'(v.exp_b[nb]));
        chk("byte_last", 32'(bus.last_o), (nb == 3) ? 32'd1 : 32'd0);
        chk("byte_ready", 32'(bus.ready_o), (nb == 3) ? 32'd1 : 32'd0);
        prev_byte = v.exp_b[nb];
        nb++;
      end
    end
    chk("word_idle_last", 32'(bus.idle_o), 32'd0);
    bus.busy0_i = 1'b0;
    bus.busy1_i = 1'b0;
    bus.busy2_i = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'hA1B2C3D4, 2'd0, 0, 0, 1'b0, {8'hA1, 8'hB2, 8'hC3, 8'hD4}};
    vecs[1] = '{32'hA1B2C3D4, 2'd2, 1, 2, 1'b0, {8'hA1, 8'hB2, 8'hC3, 8'hD4}};
    vecs[2] = '{32'h5A6B7C8D, 2'd1, 0, 0, 1'b1, {8'h5A, 8'h6B, 8'h7C, 8'h8D}};
    vecs[3] = '{32'hCAFEF00D, 2'd0, 3, 3, 1'b0, {8'hCA, 8'hFE, 8'hF0, 8'h0D}};
    vecs[4] = '{32'h0F1E2D3C, 2'd1, 0, 1, 1'b0, {8'h0F, 8'h1E, 8'h2D, 8'h3C}};

    rst          = 1'b1;
    bus.valid_i  = 1'b0;
    bus.data_i   = '0;
    bus.select_i = 2'd0;
    bus.busy0_i  = 1'b0;
    bus.busy1_i  = 1'b0;
    bus.busy2_i  = 1'b0;

    // Reset state and release.
    tick();
    tick();
    chk("rst_ready", 32'(bus.ready_o), 32'd0);
    chk("rst_valid", 32'(vmask()), 32'd0);
    chk("rst_data", 32'(bus.data_o), 32'd0);
    chk("rst_last", 32'(bus.last_o), 32'd0);
`ifdef DEMUX_DISPATCH_ERRCNT_EN
    chk("rst_err", 32'(bus.err_cnt_o), 32'd0);
`endif
    rst = 1'b0;
    #1;
    chk("rel_ready", 32'(bus.ready_o), 32'd1);
    chk("rel_idle", 32'(bus.idle_o), 32'd1);

    // Busy while idle changes nothing.
    bus.busy0_i = 1'b1;
    bus.busy2_i = 1'b1;
    tick();
    chk("idle_busy_ready", 32'(bus.ready_o), 32'd1);
    chk("idle_busy_valid", 32'(vmask()), 32'd0);
    bus.busy0_i = 1'b0;
    bus.busy2_i = 1'b0;

    // Table of words; each next accept lands on the edge after the previous last byte.
    for (int i = 0; i < 5; i++) send(vecs[i]);

    // Illegal select: dropped, ready stays high, counter saturates.
    bus.valid_i  = 1'b1;
    bus.select_i = 2'd3;
    bus.data_i   = 32'h11223344;
    tick();
    chk("ill_ready", 32'(bus.ready_o), 32'd1);
    chk("ill_valid", 32'(vmask()), 32'd0);
    chk("ill_last", 32'(bus.last_o), 32'd0);
`ifdef DEMUX_DISPATCH_ERRCNT_EN
    chk("ill_err1", 32'(bus.err_cnt_o), 32'd1);
`endif
    for (int i = 1; i < 256; i++) begin
      tick();
      chk("ill_loop_valid", 32'(vmask()), 32'd0);
`ifdef DEMUX_DISPATCH_ERRCNT_EN
      if (i == 254) chk("ill_err255", 32'(bus.err_cnt_o), 32'd255);
`endif
    end
    chk("ill_end_ready", 32'(bus.ready_o), 32'd1);
`ifdef DEMUX_DISPATCH_ERRCNT_EN
    chk("ill_err_sat", 32'(bus.err_cnt_o), 32'd255);
`endif

    // Back-to-back with valid_i held: channel 1 then channel 0, second accept at E5.
    bus.select_i = 2'd1;
    bus.data_i   = 32'h11223344;
    tick();
    bus.select_i = 2'd0;
    bus.data_i   = 32'h55667788;
    tick(); chk("b2b_v1", 32'(vmask()), 32'd2); chk("b2b_d1", 32'(bus.data_o), 32'h11);
    tick(); chk("b2b_v2", 32'(vmask()), 32'd2); chk("b2b_d2", 32'(bus.data_o), 32'h22);
    tick(); chk("b2b_v3", 32'(vmask()), 32'd2); chk("b2b_d3", 32'(bus.data_o), 32'h33);
    tick(); chk("b2b_v4", 32'(vmask()), 32'd2); chk("b2b_d4", 32'(bus.data_o), 32'h44);
    chk("b2b_last4", 32'(bus.last_o), 32'd1);
    tick();
    bus.valid_i = 1'b0;
    chk("b2b_acc_v", 32'(vmask()), 32'd0);
    chk("b2b_acc_ready", 32'(bus.ready_o), 32'd0);
    chk("b2b_acc_hold", 32'(bus.data_o), 32'h44);
    tick(); chk("b2b_v5", 32'(vmask()), 32'd1); chk("b2b_d5", 32'(bus.data_o), 32'h55);
    tick(); chk("b2b_v6", 32'(vmask()), 32'd1); chk("b2b_d6", 32'(bus.data_o), 32'h66);
    tick(); chk("b2b_v7", 32'(vmask()), 32'd1); chk("b2b_d7", 32'(bus.data_o), 32'h77);
    tick(); chk("b2b_v8", 32'(vmask()), 32'd1); chk("b2b_d8", 32'(bus.data_o), 32'h88);
    chk("b2b_last8", 32'(bus.last_o), 32'd1);
    tick();
    chk("b2b_idle", 32'(bus.idle_o), 32'd1);

    // Asynchronous reset in the middle of 0xDEADBEEF.
    bus.valid_i  = 1'b1;
    bus.select_i = 2'd0;
    bus.data_i   = 32'hDEADBEEF;
    tick();
    bus.valid_i = 1'b0;
    tick();
    tick();
    chk("mid_d2", 32'(bus.data_o), 32'hAD);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_data", 32'(bus.data_o), 32'd0);
    chk("arst_valid", 32'(vmask()), 32'd0);
    chk("arst_last", 32'(bus.last_o), 32'd0);
    chk("arst_ready", 32'(bus.ready_o), 32'd0);
    tick();
    chk("arst_hold_valid", 32'(vmask()), 32'd0);
    rst = 1'b0;
    #1;
    chk("arst_rel_ready", 32'(bus.ready_o), 32'd1);
    prev_byte = 8'h00;
    begin
      vec_t v;
      v = '{32'h01020304, 2'd1, 0, 0, 1'b0, {8'h01, 8'h02, 8'h03, 8'h04}};
      send(v);
    end
    tick();
    chk("final_idle", 32'(bus.idle_o), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/demux_dispatch_ctrl.md
# demux_dispatch_ctrl

Single-clock dispatch controller for the decryption datapath. It accepts 32-bit ciphertext words with a channel select from the master side and serialises each word MSB-byte-first onto a shared byte bus. Each byte goes to exactly one of three decryptor channels. The block honours per-channel busy back-pressure and throttles the master with a ready handshake, replacing free-running byte slicing with a sequenced, stall-safe transfer.

## Interface
- MST_DWIDTH, 32, input word width; must be an integer multiple of SYS_DWIDTH
- SYS_DWIDTH, 8, output byte width; BYTES = MST_DWIDTH/SYS_DWIDTH (4 by default)
- clk_sys  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- data_i  in  MST_DWIDTH  ciphertext word
- valid_i  in  1  word present on data_i/select_i
- select_i  in  2  target channel: 0, 1, 2; value 3 is illegal
- ready_o  out  1  block can accept a word
- busy0_i, busy1_i, busy2_i  in  1 each  per-channel stall request from decryptor
- data_o  out  SYS_DWIDTH  shared byte bus
- valid0_o, valid1_o, valid2_o  out  1 each  byte strobe per channel, at most one high
- last_o  out  1  qualifies final byte of a word; high together with the active valid
- idle_o  out  1  state == IDLE and no byte strobe this cycle

## Operation
- A word is accepted on a rising edge where valid_i && ready_o; ready_o = (state == IDLE), combinational from state.
- States:
  - IDLE: on accept with select_i in {0,1,2}, latch word and channel, set idx=0, go to SEND. On accept with select_i == 3, drop the word, raise an error event, stay in IDLE.
  - SEND: each edge where busy of the latched channel is low, register data_o = word[MST_DWIDTH-1-SYS_DWIDTH*idx -: SYS_DWIDTH] and valid<ch>_o = 1, then increment idx. When idx == BYTES-1 is issued, last_o = 1 and the next state is IDLE.
  - SEND, busy high: on that edge valid<ch>_o = 0, idx holds, word holds.
- Only the latched channel's busy is observed; busy on other channels is ignored.
- data_o keeps its last value when no valid is high. last_o is never high without a valid.
- idx is clog2(BYTES) bits and never wraps mid-word; it resets to 0 on every accept.
- select_i and data_i are ignored while ready_o is low, and no word is buffered beyond the one being sent.
- Reset, at any time including mid-word: state=IDLE, idx=0, word=0, data_o=0, valid0..2_o=0, last_o=0, error counter=0. The partially sent word is discarded. ready_o=0 while rst is high and 1 on the first cycle after release.

## Timing
- Accept edge E0; first byte visible after E1 when busy is low. Minimum latency is 1 cycle.
- No stalls: bytes appear after E1..E4, last_o is high after E4, ready_o is high after E4, and the next accept is at E5. Throughput is one word per BYTES+1 cycles.
- Each busy-high cycle during SEND adds exactly one cycle. Busy asserted during IDLE has no effect.
- Outputs are registered. Only ready_o and idle_o are derived from state and output registers.

## Configuration
- DEMUX_DISPATCH_ERRCNT_EN defined: adds output err_cnt_o [7:0], which increments on each dropped select==3 word and saturates at 255. It resets to 0.
- Macro undefined: no err_cnt_o port. Illegal words are dropped silently with identical timing.

## Structure
- Shared package decrypt_pkg holds:
  - the state enum (IDLE, SEND)
  - channel constants CH_CAESAR=0, CH_SCYTALE=1, CH_ZIGZAG=2, CH_ILLEGAL=3
  - default width constants 32/8
- No sub-module. The byte slice is an indexed part-select inside the FSM process.

## Test plan
- Reset release, valid_i=1, data_i=0xA1B2C3D4, select_i=0, busy low -> valid0_o high for 4 cycles carrying A1, B2, C3, D4; last_o with D4; ready_o low for exactly 4 cycles.
- Same word with select_i=2 and busy2_i high for 2 cycles after the first byte -> bytes A1 then a 2-cycle gap then B2, C3, D4; valid1_o and valid0_o stay 0.
- select_i=3, data_i=0x11223344 -> no valid, ready_o stays 1; with macro, err_cnt_o goes 0 -> 1; 256 illegal words give err_cnt_o=255.
- Back-to-back words to channels 1 then 0 with valid_i held high -> second accept at E5; valid1_o bytes then valid0_o bytes with no overlap.
- rst pulsed after the second byte of 0xDEADBEEF -> all outputs 0 immediately (asynchronous). After release, a fresh word 0x01020304 on channel 1 -> 01, 02, 03, 04 with no DE/AD residue.
- busy0_i toggling while sending to channel 1 -> no effect on the channel-1 byte cadence.
